// File: rtl/ctrl_fsm_mc.sv
// Multicycle control FSM for the 16-opcode ISA with a latched opcode and a memory-wait timeout.
// Define CTRL_TRAP_EN to route opcode 9 through a TRAP state.
`default_nettype none

module ctrl_fsm_mc #(
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               run,
  input  logic [3:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ra_write,
  output logic               ir_write,
  output logic               mem_req,
  output logic               mem_src,
  output logic               mem_we,
  output logic               reg_r,
  output logic               reg_w1,
  output logic               reg_w2,
  output logic [1:0]         reg_src,
  output logic               cr_write,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               cmp_eq,
  output logic               cmp_ne,
  output logic               backup,
  output logic               restore,
  output logic               trap,
  output logic               mem_err,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_CALL   = 4'd8,
    S_RET    = 4'd9,
    S_TRAP   = 4'd10
  } state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          wait_st, tmo;
  state_e        nxt_b;

  always_comb begin
    nxt_b   = run ? S_FETCH : S_IDLE;
    wait_st = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    tmo     = wait_st && (TIMEOUT > 0) && (cnt_q == LIM);
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    cnt_d   = '0;
    if (wait_st && !tmo) cnt_d = cnt_q + 1'b1;
    if (tmo) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (run && !err_q) state_d = S_FETCH;
        S_FETCH:
          if (mem_ready) begin
            op_d    = op;
            state_d = S_DECODE;
          end
        S_DECODE:
          unique case (op_q)
            4'd0, 4'd2, 4'd7, 4'd10,
            4'd12, 4'd13, 4'd14, 4'd15: state_d = S_EXEC;
            4'd1, 4'd8:                 state_d = S_WB;
            4'd5, 4'd6:                 state_d = S_BRANCH;
            4'd3:                       state_d = S_JUMP;
            4'd4:                       state_d = S_CALL;
            4'd11:                      state_d = S_RET;
`ifdef CTRL_TRAP_EN
            default:                    state_d = S_TRAP;
`else
            default:                    state_d = nxt_b;
`endif
          endcase
        S_EXEC:
          state_d = (op_q == 4'd0 || op_q == 4'd2) ? S_MEM : S_WB;
        S_MEM:
          if (mem_ready) state_d = (op_q == 4'd2) ? nxt_b : S_WB;
        S_WB, S_BRANCH, S_JUMP, S_CALL, S_RET, S_TRAP:
          state_d = nxt_b;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Decoded from registered state; only the fetch strobes see mem_ready.
  always_comb begin
    pc_write = 1'b0;
    pc_src   = 2'd0;
    ra_write = 1'b0;
    ir_write = 1'b0;
    mem_req  = 1'b0;
    mem_src  = 1'b0;
    mem_we   = 1'b0;
    reg_r    = 1'b0;
    reg_w1   = 1'b0;
    reg_w2   = 1'b0;
    reg_src  = 2'd0;
    cr_write = 1'b0;
    alu_src  = 1'b0;
    alu_op   = '0;
    cmp_eq   = 1'b0;
    cmp_ne   = 1'b0;
    backup   = 1'b0;
    restore  = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: reg_r = 1'b1;
      S_EXEC: begin
        alu_src = (op_q == 4'd10) || (op_q >= 4'd12);
        unique case (1'b1)
          op_q == 4'd7:  alu_op = ALUOP_W'(4);
          op_q == 4'd13: alu_op = ALUOP_W'(3);
          op_q == 4'd14: alu_op = ALUOP_W'(0);
          op_q == 4'd15: alu_op = ALUOP_W'(1);
          op_q == 4'd10: alu_op = ALUOP_W'(5);
          default:       alu_op = ALUOP_W'(2);
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_src = 1'b1;
        mem_we  = (op_q == 4'd2);
      end
      S_WB: begin
        unique case (1'b1)
          op_q == 4'd1: reg_src = 2'd0;
          op_q == 4'd0: reg_src = 2'd1;
          op_q == 4'd8: reg_src = 2'd3;
          default:      reg_src = 2'd2;
        endcase
        reg_w1   = (op_q == 4'd10);
        cr_write = (op_q == 4'd10);
        reg_w2   = (op_q != 4'd10);
      end
      S_BRANCH: begin
        cmp_eq = (op_q == 4'd5);
        cmp_ne = (op_q == 4'd6);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
      end
      S_CALL: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        ra_write = 1'b1;
        backup   = 1'b1;
      end
      S_RET: begin
        pc_write = 1'b1;
        pc_src   = 2'd1;
        restore  = 1'b1;
      end
`ifdef CTRL_TRAP_EN
      S_TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_src   = 2'd3;
        ra_write = 1'b1;
        backup   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign mem_err = err_q;
  assign state   = state_q;

endmodule

`default_nettype wire
